// File: rtl/fifo_wr_arbiter_if.sv
// Producer request/grant bus plus the FIFO write-port handshake used by fifo_wr_arbiter.
// The arbiter connects through the slave modport; the producer/FIFO side uses master.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  logic                          en;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic [15:0]                   wr_count;
  logic                          ovf_err;

  modport slave (
    input  en, req, req_data,
    input  fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, wr_count, ovf_err
  );

  modport master (
    output en, req, req_data,
    output fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in, wr_count, ovf_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port among NUM_REQ producers.
// Grants, write enable and write data are registered. Issue is throttled by the FIFO
// full/almostfull flags; acknowledged writes are counted and overflows latched.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave arb
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDX_W-1:0] idx_t;

  // Bit 0 of the encoding is the FIFO write enable, so fifo_wr_en comes straight off a flop.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    STALL = 2'b10
  } state_t;

  // Registered state
  state_t                 state_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [DATA_WIDTH-1:0]  data_q;
  idx_t                   last_q;
  logic [15:0]            wr_count_q;
  logic                   ovf_err_q;

  // Combinational decision
  logic [NUM_REQ-1:0]     eligible;
  logic                   full_guard;
  logic                   issue;
  logic                   found;
  idx_t                   cand;
  idx_t                   winner_d;
  logic [NUM_REQ-1:0]     gnt_d;
  logic [DATA_WIDTH-1:0]  data_d;

  // Cyclic successor of a producer index, wrapping at NUM_REQ-1.
  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // The producer granted this cycle still shows its old req at the next edge; mask it
  // so one request is never granted twice.
  assign eligible = arb.req & ~gnt_q;

  // Conservative full guard: a write in flight into an almost-full FIFO fills it.
  assign full_guard = arb.fifo_full | (arb.fifo_almostfull & state_q[0]);

  assign issue = arb.en & ~full_guard & (|eligible);

  // Round-robin search: first eligible producer after last_q, wrapping around.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    winner_d = last_q;
    found    = 1'b0;
    cand     = next_idx(last_q);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && eligible[cand]) begin
        winner_d = cand;
        found    = 1'b1;
      end
      cand = next_idx(cand);
    end
  end

  // Decode the winner into a one-hot grant and select its data slice.
  always_comb begin
    gnt_d  = '0;
    data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_d == idx_t'(i)) begin
        gnt_d[i] = 1'b1;
        data_d   = arb.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM with registered grant, write enable and write data.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      last_q  <= idx_t'(NUM_REQ - 1);
    end else if (issue) begin
      state_q <= GRANT;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      last_q  <= winner_d;
    end else begin
      // Pending work that is blocked only by the guard is a stall; anything else is idle.
      state_q <= (arb.en && (|eligible)) ? STALL : IDLE;
      gnt_q   <= '0;
    end
  end

  // Saturating count of FIFO write acknowledges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q <= '0;
    end else if (arb.fifo_wr_ack && (wr_count_q != 16'hFFFF)) begin
      wr_count_q <= wr_count_q + 16'd1;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
    end else if (arb.fifo_overflow) begin
      ovf_err_q <= 1'b1;
    end
  end

  assign arb.gnt          = gnt_q;
  assign arb.fifo_wr_en   = state_q[0];
  assign arb.fifo_data_in = data_q;
  assign arb.wr_count     = wr_count_q;
  assign arb.ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed producer loads push the hand-ordered
// expected writes; a monitor pops and compares on every fifo_wr_en cycle.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int DEPTH   = 8;

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic [DW-1:0]      data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rd;
  logic force_ovf;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb_q[$];
  exp_t   mon_e;
  int     gnt_cnt [NUM_REQ];
  logic [DW-1:0] prod_q [NUM_REQ][$];

  // ---------------- FIFO model (depth 8, no reads unless rd) ----------------
  int   fifo_cnt;
  logic model_ack;
  logic model_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt  <= 0;
      model_ack <= 1'b0;
      model_ovf <= 1'b0;
    end else begin
      model_ack <= bus.fifo_wr_en && (fifo_cnt < DEPTH);
      model_ovf <= bus.fifo_wr_en && (fifo_cnt == DEPTH);
      fifo_cnt  <= fifo_cnt + ((bus.fifo_wr_en && fifo_cnt < DEPTH) ? 1 : 0)
                            - ((rd && fifo_cnt > 0) ? 1 : 0);
    end
  end

  assign bus.fifo_full       = (fifo_cnt == DEPTH);
  assign bus.fifo_almostfull = (fifo_cnt == DEPTH - 1);
  assign bus.fifo_wr_ack     = model_ack;
  assign bus.fifo_overflow   = model_ovf | force_ovf;

  // ---------------- Producers: hold req/data until granted ----------------
  always @(negedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rst && bus.gnt[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
      bus.req[i] = (prod_q[i].size() > 0);
      bus.req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
  end

  // ---------------- Checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the next expected entry; no grant without a write.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_wr_en) begin
        for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) gnt_cnt[i]++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: gnt=%b data=%h, expected no write (t=%0t)",
                   bus.gnt, bus.fifo_data_in, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("wr_gnt", 32'(bus.gnt), 32'(mon_e.gnt));
          check("wr_data", 32'(bus.fifo_data_in), 32'(mon_e.data));
        end
      end else begin
        check("gnt_without_wr", 32'(bus.gnt), 32'd0);
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input logic [DW-1:0] d);
    prod_q[p].push_back(d);
  endtask

  task automatic expect_wr(input int p, input logic [DW-1:0] d);
    exp_t e;
    e.gnt  = NUM_REQ'(1) << p;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic count_wr(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      cyc(1);
      if (bus.fifo_wr_en) n++;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && sb_q.size() > 0; c++) cyc(1);
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    check("rst_data", 32'(bus.fifo_data_in), 32'd0);
    check("rst_wr_count", 32'(bus.wr_count), 32'd0);
    check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- Directed tests ----------------
  initial begin
    int n;
    logic [7:0] pat;
    rst       = 1'b1;
    rd        = 1'b0;
    force_ovf = 1'b0;
    bus.en    = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i] = 0;

    // Test 1: reset, then a single request from producer 2.
    reset_dut();
    load(2, 16'hA5A5);
    expect_wr(2, 16'hA5A5);
    cyc(1);
    check("t1_gnt", 32'(bus.gnt), 32'h4);
    check("t1_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    check("t1_data", 32'(bus.fifo_data_in), 32'hA5A5);
    cyc(1);
    check("t1_wr_count_lag", 32'(bus.wr_count), 32'd0);
    cyc(1);
    check("t1_wr_count", 32'(bus.wr_count), 32'd1);
    count_wr(4, n);
    check("t1_no_second_gnt", 32'(n), 32'd0);
    wait_drain("t1_drain", 5);

    // Test 2: all four producers, two writes each -> 0,1,2,3,0,1,2,3 back to back.
    reset_dut();
    for (int i = 0; i < NUM_REQ; i++) gnt_cnt[i] = 0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_REQ; p++) begin
        load(p, 16'(p * 16'h1000 + 16'h0200 + r));
        expect_wr(p, 16'(p * 16'h1000 + 16'h0200 + r));
      end
    count_wr(8, n);
    check("t2_writes_in_8_cycles", 32'(n), 32'd8);
    wait_drain("t2_drain", 4);
    for (int i = 0; i < NUM_REQ; i++) check("t2_per_producer", 32'(gnt_cnt[i]), 32'd2);

    // Test 3: 10 writes from producers 0/1 into a depth-8 FIFO with no reads.
    reset_dut();
    for (int j = 0; j < 5; j++) begin
      load(0, 16'(16'h0A00 + j));
      load(1, 16'(16'h1B00 + j));
      if (j < 4) begin
        expect_wr(0, 16'(16'h0A00 + j));
        expect_wr(1, 16'(16'h1B00 + j));
      end
    end
    count_wr(14, n);
    check("t3_writes_before_stall", 32'(n), 32'd8);
    check("t3_sb_after_fill", 32'(sb_q.size()), 32'd0);
    check("t3_wr_count", 32'(bus.wr_count), 32'd8);
    check("t3_ovf_err", 32'(bus.ovf_err), 32'd0);
    expect_wr(0, 16'h0A04);
    expect_wr(1, 16'h1B04);
    rd = 1'b1;
    cyc(3);
    rd = 1'b0;
    wait_drain("t3_drain_after_reads", 10);
    cyc(3);
    check("t3_wr_count_final", 32'(bus.wr_count), 32'd10);
    check("t3_ovf_err_final", 32'(bus.ovf_err), 32'd0);

    // Test 4: producer 3 alone, req held continuously -> grant every other cycle.
    reset_dut();
    for (int j = 0; j < 4; j++) begin
      load(3, 16'(16'h3C00 + j));
      expect_wr(3, 16'(16'h3C00 + j));
    end
    pat = '0;
    for (int c = 0; c < 8; c++) begin
      cyc(1);
      pat[c] = bus.gnt[3];
    end
    check("t4_alternate_pattern", 32'(pat), 32'h55);
    wait_drain("t4_drain", 4);

    // Test 5: en gating, then reset during a GRANT cycle.
    reset_dut();
    bus.en = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_REQ; p++) load(p, 16'(16'h5000 + p * 16'h0100 + r));
    count_wr(5, n);
    check("t5_en_low_grants", 32'(n), 32'd0);
    bus.en = 1'b1;
    cyc(1);
    check("t5_pre_rst_gnt", 32'(bus.gnt), 32'h1);
    check("t5_pre_rst_wr_en", 32'(bus.fifo_wr_en), 32'd1);
    check("t5_pre_rst_data", 32'(bus.fifo_data_in), 32'h5000);
    rst = 1'b1;
    #1;
    check("t5_rst_gnt", 32'(bus.gnt), 32'd0);
    check("t5_rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
    cyc(2);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NUM_REQ; p++) expect_wr(p, 16'(16'h5000 + p * 16'h0100 + r));
    rst = 1'b0;
    wait_drain("t5_drain", 20);

    // Test 6: a forced overflow pulse sets the sticky flag without touching wr_count.
    cyc(3);
    check("t6_wr_count_base", 32'(bus.wr_count), 32'd8);
    force_ovf = 1'b1;
    cyc(1);
    force_ovf = 1'b0;
    check("t6_ovf_err_set", 32'(bus.ovf_err), 32'd1);
    cyc(5);
    check("t6_ovf_err_sticky", 32'(bus.ovf_err), 32'd1);
    check("t6_wr_count_unchanged", 32'(bus.wr_count), 32'd8);
    reset_dut();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
